// File: rtl/picoblaze_io_hub.sv
// picoblaze_io_hub
//   I/O and interrupt hub between a pacoblaze3 core and board logic.
//   Fixed address map:
//     0x00+n  input port n (read only)
//     0x10+n  output register n (read/write, one-cycle out_we pulse on write)
//     0xF0    PENDING  (bit0 timer, bit k+1 irq_lines[k]); write-1-to-clear
//     0xF1    MASK
//     0xF2/F3 timer reload bytes [7:0]/[15:8] (staged on write, committed read back)
//     0xF4    timer reload [23:16]; write commits all three bytes, clears count
//     0xF5    CTRL, bit0 = timer enable
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     port_id, write_strobe, read_strobe, out_port   core I/O bus
//     in_port               registered read data (one cycle after port_id)
//     interrupt, interrupt_ack   latched request / one-cycle acknowledge
//     in_data, out_data, out_we  board-side ports, 8 bits per port
//     irq_lines             external rising-edge interrupt sources
module picoblaze_io_hub #(
  parameter int          NUM_IN        = 2,
  parameter int          NUM_OUT       = 4,
  parameter int          NUM_IRQ       = 4,
  parameter int unsigned TIMER_DEFAULT = 250000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  port_id,
  input  logic                        write_strobe,
  input  logic                        read_strobe,
  input  logic [7:0]                  out_port,
  output logic [7:0]                  in_port,
  output logic                        interrupt,
  input  logic                        interrupt_ack,
  input  logic [NUM_IN*8-1:0]         in_data,
  output logic [NUM_OUT*8-1:0]        out_data,
  output logic [NUM_OUT-1:0]          out_we,
  input  logic [((NUM_IRQ > 0) ? NUM_IRQ : 1)-1:0] irq_lines
);

  localparam int IRQW = (NUM_IRQ > 0) ? NUM_IRQ : 1;
  localparam int PW   = NUM_IRQ + 1;
  localparam logic [23:0] RELOAD_RST = 24'(TIMER_DEFAULT);

  logic [PW-1:0] pending;
  logic [PW-1:0] mask;
  logic          tmr_en;
  logic [23:0]   reload;
  logic [23:0]   count;
  logic [7:0]    stage_lo;
  logic [7:0]    stage_mid;

  logic          tmr_run;
  logic          tmr_evt;
  logic [PW-1:0] evt;
  logic          wr_pend, wr_mask, wr_lo, wr_mid, wr_hi, wr_ctrl;
  logic [PW-1:0] pend_clr;
  logic [PW-1:0] mask_next;
  logic          raise;
  logic [7:0]    rd_data;

  // The read qualifier is informational only; the read mux runs every cycle.
  logic unused_inputs;
  assign unused_inputs = read_strobe ^ (^irq_lines);

  assign wr_pend = write_strobe && (port_id == 8'hF0);
  assign wr_mask = write_strobe && (port_id == 8'hF1);
  assign wr_lo   = write_strobe && (port_id == 8'hF2);
  assign wr_mid  = write_strobe && (port_id == 8'hF3);
  assign wr_hi   = write_strobe && (port_id == 8'hF4);
  assign wr_ctrl = write_strobe && (port_id == 8'hF5);

  assign tmr_run = tmr_en && (reload != 24'd0);
  assign tmr_evt = tmr_run && (count == reload - 24'd1);

  generate
    if (NUM_IRQ > 0) begin : g_irq
      logic [IRQW-1:0] irq_prev;
      always_ff @(posedge clk) begin
        if (reset) irq_prev <= '0;
        else       irq_prev <= irq_lines;
      end
      assign evt = {irq_lines & ~irq_prev, tmr_evt};
    end else begin : g_no_irq
      assign evt = tmr_evt;
    end
  endgenerate

  assign pend_clr  = wr_pend ? out_port[PW-1:0] : '0;
  assign mask_next = wr_mask ? out_port[PW-1:0] : mask;
  // Raise on a freshly unmasked event, or when a MASK write exposes a bit
  // that was already pending.
  assign raise = (|(evt & mask_next)) ||
                 (wr_mask && (|(out_port[PW-1:0] & ~mask & pending)));

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_IN; i++)
      if (port_id == 8'(i)) rd_data = in_data[i*8 +: 8];
    for (int i = 0; i < NUM_OUT; i++)
      if (port_id == 8'(16 + i)) rd_data = out_data[i*8 +: 8];
    case (port_id)
      8'hF0:   rd_data = 8'(pending);
      8'hF1:   rd_data = 8'(mask);
      8'hF2:   rd_data = reload[7:0];
      8'hF3:   rd_data = reload[15:8];
      8'hF4:   rd_data = reload[23:16];
      8'hF5:   rd_data = {7'd0, tmr_en};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_port   <= 8'h00;
      out_data  <= '0;
      out_we    <= '0;
      interrupt <= 1'b0;
      pending   <= '0;
      mask      <= '0;
      tmr_en    <= 1'b1;
      reload    <= RELOAD_RST;
      count     <= 24'd0;
      stage_lo  <= 8'h00;
      stage_mid <= 8'h00;
    end else begin
      in_port <= rd_data;

      out_we <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (write_strobe && (port_id == 8'(16 + i))) begin
          out_data[i*8 +: 8] <= out_port;
          out_we[i]          <= 1'b1;
        end
      end

      // Set beats clear on the same bit.
      pending <= (pending & ~pend_clr) | evt;
      mask    <= mask_next;

      if (raise)              interrupt <= 1'b1;
      else if (interrupt_ack) interrupt <= 1'b0;

      if (wr_ctrl) tmr_en    <= out_port[0];
      if (wr_lo)   stage_lo  <= out_port;
      if (wr_mid)  stage_mid <= out_port;

      if (wr_hi) begin
        reload <= {out_port, stage_mid, stage_lo};
        count  <= 24'd0;
      end else if (!tmr_run || tmr_evt) begin
        count <= 24'd0;
      end else begin
        count <= count + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_picoblaze_io_hub.sv
module tb_picoblaze_io_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic [15:0] in_data;
  logic [31:0] out_data;
  logic [3:0]  out_we;
  logic [3:0]  irq_lines;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  picoblaze_io_hub #(
    .NUM_IN(2), .NUM_OUT(4), .NUM_IRQ(4), .TIMER_DEFAULT(250000)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .in_data(in_data),
    .out_data(out_data), .out_we(out_we), .irq_lines(irq_lines)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge; one rising edge in between.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    port_id = a; read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    chk(tag, {24'd0, in_port}, {24'd0, exp});
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = 8'h00; interrupt_ack = 1'b0; in_data = 16'h3CA5; irq_lines = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_we", {28'd0, out_we}, 32'h0);
    chk("rst_in_port", {24'd0, in_port}, 32'h0);
    chk("rst_interrupt", {31'd0, interrupt}, 32'h0);

    // Read path
    rd("rd_in0", 8'h00, 8'hA5);
    rd("rd_in1", 8'h01, 8'h3C);
    rd("rd_unmapped", 8'h33, 8'h00);
    rd("rd_mask_rst", 8'hF1, 8'h00);
    rd("rd_reload_hi", 8'hF4, 8'h03);
    rd("rd_reload_lo", 8'hF2, 8'h90);
    rd("rd_ctrl_rst", 8'hF5, 8'h01);
    rd("rd_pend_rst", 8'hF0, 8'h00);

    // Write path
    wr(8'h11, 8'h5C);
    chk("wr_out_data", out_data, 32'h00005C00);
    chk("wr_out_we", {28'd0, out_we}, 32'h2);
    @(negedge clk);
    chk("wr_out_we_drop", {28'd0, out_we}, 32'h0);
    rd("rd_out1", 8'h11, 8'h5C);
    wr(8'h1F, 8'hFF);
    chk("wr_oob_data", out_data, 32'h00005C00);
    chk("wr_oob_we", {28'd0, out_we}, 32'h0);

    // Timer: reload 10, commit at edge E0, events at E10, E20, ...
    wr(8'hF2, 8'h0A);
    wr(8'hF3, 8'h00);
    wr(8'hF4, 8'h00);
    wr(8'hF1, 8'h01);                 // E1
    repeat (8) @(negedge clk);        // after E9
    chk("tmr_pre1", {31'd0, interrupt}, 32'h0);
    @(negedge clk);                   // after E10
    chk("tmr_irq1", {31'd0, interrupt}, 32'h1);
    ack();                            // E11
    chk("tmr_ack", {31'd0, interrupt}, 32'h0);
    rd("tmr_pend_held", 8'hF0, 8'h01); // E12
    repeat (7) @(negedge clk);        // after E19
    chk("tmr_pre2", {31'd0, interrupt}, 32'h0);
    @(negedge clk);                   // after E20
    chk("tmr_irq2", {31'd0, interrupt}, 32'h1);
    wr(8'hF0, 8'h01);
    rd("tmr_pend_clr", 8'hF0, 8'h00);
    wr(8'hF5, 8'h00);
    wr(8'hF1, 8'h00);
    ack();
    chk("tmr_ack2", {31'd0, interrupt}, 32'h0);
    rd("rd_ctrl_off", 8'hF5, 8'h00);
    rd("rd_reload_lo10", 8'hF2, 8'h0A);
    rd("rd_reload_mid10", 8'hF3, 8'h00);

    // Masked external edge, then unmasking an already pending bit
    irq_lines = 4'b0100;
    @(negedge clk);
    chk("irq2_masked", {31'd0, interrupt}, 32'h0);
    rd("irq2_pend", 8'hF0, 8'h08);
    wr(8'hF1, 8'h08);
    chk("irq2_unmask", {31'd0, interrupt}, 32'h1);
    ack();
    chk("irq2_ack", {31'd0, interrupt}, 32'h0);
    wr(8'hF0, 8'h08);
    wr(8'hF1, 8'h00);
    irq_lines = 4'b0000;
    @(negedge clk);

    // A held level produces a single edge
    irq_lines = 4'b0001;
    repeat (20) @(negedge clk);
    rd("irq0_pend", 8'hF0, 8'h02);
    wr(8'hF0, 8'h02);
    rd("irq0_level_once", 8'hF0, 8'h00);
    chk("irq0_masked", {31'd0, interrupt}, 32'h0);
    irq_lines = 4'b0000;
    @(negedge clk);
    irq_lines = 4'b0001;
    wr(8'hF0, 8'h02);                 // clear and new edge together
    rd("set_beats_clr", 8'hF0, 8'h02);

    // Mid-operation reset
    wr(8'hF1, 8'h02);
    chk("pre_rst_irq", {31'd0, interrupt}, 32'h1);
    wr(8'hF5, 8'h01);
    wr(8'hF2, 8'h77);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out_data", out_data, 32'h0);
    chk("mid_rst_in_port", {24'd0, in_port}, 32'h0);
    chk("mid_rst_irq", {31'd0, interrupt}, 32'h0);
    irq_lines = 4'b0000;
    rd("mid_rst_mask", 8'hF1, 8'h00);
    rd("mid_rst_pend", 8'hF0, 8'h00);
    rd("mid_rst_lo", 8'hF2, 8'h90);
    rd("mid_rst_mid", 8'hF3, 8'hD0);
    rd("mid_rst_hi", 8'hF4, 8'h03);
    rd("mid_rst_ctrl", 8'hF5, 8'h01);
    rd("mid_rst_out1", 8'h11, 8'h00);
    wr(8'hF4, 8'h00);                 // commits {0, staged mid, staged lo}
    rd("stage_discard_lo", 8'hF2, 8'h00);
    rd("stage_discard_mid", 8'hF3, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/picoblaze_io_hub.md
Name: picoblaze_io_hub

Overview:
Parametrised I/O and interrupt hub sitting between a pacoblaze3 core and the board logic. It replaces per-design hand-wired port decode with a fixed address map of NUM_IN input ports, NUM_OUT read-back output registers and an interrupt controller. The controller has a programmable periodic timer plus NUM_IRQ external edge-triggered sources, each with pending and mask bits. in_port is a registered (pipelined) read mux; interrupt is latched until interrupt_ack.

Parameters:
NUM_IN, 2, number of 8-bit input ports (1..16)
NUM_OUT, 4, number of 8-bit output registers (1..16)
NUM_IRQ, 4, number of external interrupt lines (0..7)
TIMER_DEFAULT, 250000, timer reload value after reset (24-bit, cycles per tick)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
port_id  input  8  core port address
write_strobe  input  1  core write qualifier
read_strobe  input  1  core read qualifier (informational; read mux is not gated by it)
out_port  input  8  core write data
in_port  output  8  registered read data to core
interrupt  output  1  interrupt request to core
interrupt_ack  input  1  one-cycle acknowledge from core
in_data  input  NUM_IN*8  input port n at bits [8n+7:8n]; synchronous to clk
out_data  output  NUM_OUT*8  output register n at bits [8n+7:8n]
out_we  output  NUM_OUT  one-cycle pulse: output register n was written
irq_lines  input  max(NUM_IRQ,1)  external sources; synchronous, rising-edge sensitive

Behaviour:
- Reset (clk edge with reset=1): out_data=0, out_we=0, in_port=0x00, interrupt=0, pending=0, mask=0, timer enable=1, reload=TIMER_DEFAULT, timer count=0, staged reload bytes=0, irq edge history=0. Reset overrides all writes and events in the same cycle.
- Address map:
  - 0x00+n: input n, read only.
  - 0x10+n: output n, read/write.
  - 0xF0: PENDING. Read; write-1-to-clear. Bit0=timer, bit k+1=irq_lines[k]; unused bits read 0.
  - 0xF1: MASK, read/write.
  - 0xF2/0xF3: reload bytes [7:0]/[15:8], staged.
  - 0xF4: reload [23:16]. Writing it commits all three bytes and clears the timer count.
  - 0xF5: CTRL, bit0=timer enable, other bits read 0.
  - Any other address: reads 0x00, writes ignored.
- Read path: every cycle, in_port <= data selected by port_id (1-cycle latency, independent of read_strobe). Reads of 0xF2/0xF3 return committed reload bytes, not staged ones.
- Write path: when write_strobe=1 and port_id=0x10+n, out_data[n] <= out_port and out_we[n]=1 on that same edge; out_we deasserts the next cycle unless rewritten.
- Timer:
  - Enable=1 and reload!=0: count increments each cycle. When count==reload-1, count<=0 and timer event fires (one cycle).
  - Enable=0 or reload==0: count held at 0, no events.
- Edge detect: event on irq k when irq_lines[k]=1 and its previous-cycle value was 0.
- Pending: bit set on its event. Bit cleared by a write-1 to 0xF0. A set and a clear on the same bit in the same cycle: set wins.
- Interrupt raise condition (any one of):
  - an event on a bit whose MASK=1 (mask value after this cycle's write);
  - a MASK write that turns on a bit whose pending is already 1.
- interrupt <= 1 on the raise condition. Otherwise interrupt <= 0 on interrupt_ack. Otherwise hold. Raise beats ack in the same cycle.
- Masked-off events still set pending but do not raise interrupt.
- Mid-operation reset: staged reload bytes are discarded and the timer restarts from count 0 with TIMER_DEFAULT.

Test Plan:
- Reset, then read 0x00 with in_data[7:0]=0xA5: in_port=0xA5 one cycle after port_id is presented. Read 0x33: 0x00. Read 0xF1: 0x00. Read 0xF4: 0x03 (TIMER_DEFAULT=250000=0x03D090).
- Write 0x5C to 0x11: out_data[15:8]=0x5C, out_we=4'b0010 for exactly one cycle. Read 0x11: 0x5C. Write to 0x1F (NUM_OUT=4): no change.
- Write 0x00/0x00 to 0xF2/0xF3, then 0x00 to 0xF4? Instead: reload=10 (0x0A, 0x00, 0x00), MASK=0x01. Required: interrupt rises every 10 cycles. Pulse interrupt_ack: interrupt drops next cycle. PENDING bit0 stays 1 until 0x01 is written to 0xF0.
- MASK=0, rising edge on irq_lines[2]: PENDING=0x08, interrupt stays 0. Then write MASK=0x08: interrupt=1 one cycle later.
- Hold irq_lines[0]=1 for 20 cycles: exactly one pending set. Write-1-clear to bit1 in the same cycle as a new edge on irq_lines[0]: bit1 remains 1.
- Assert reset mid-count after staging 0xF2 only: staged byte discarded. Timer period returns to 250000 cycles and all outputs return to their reset values.
